sha256_digest_collector: RTL and testbench

Receive-side companion to the SHA256 core. It accepts the core's serialized 16-bit hash output stream (one word per cycle, final word flagged) and reassembles it into a full 256-bit digest register. It then presents the digest to a downstream consumer under a valid/ack handshake. It also detects malformed streams (wrong word count, overrun while a digest is still pending).

---
 rtl/sha256_pkg.sv | 94 +++++++++
 rtl/sha256_digest_collector_if.sv | 25 ++
 rtl/sha256_word_shifter.sv | 42 ++++
 rtl/sha256_digest_collector.sv | 139 +++++++++++++
 tb/tb_sha256_digest_collector.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA256 digest collector.
// Holds the FSM enum, size defaults and a reference digest.
package sha256_pkg;

    localparam int WORD_W   = 16;
    localparam int DIGEST_W = 256;
    localparam int WORDS    = DIGEST_W / WORD_W;

    typedef enum logic [1:0] {
        COLLECT_IDLE = 2'd0,
        COLLECT_RUN  = 2'd1,
        COLLECT_HOLD = 2'd2
    } collect_state_t;

    localparam logic [2047:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    // Single-block SHA-256 of an already padded 512-bit block, so the
    // reference digest below is derived rather than typed in by hand.
    function automatic logic [255:0] sha256_block(input logic [511:0] blk);
        logic [2047:0] w;
        logic [31:0]   a, b, c, d, e, f, g, h;
        logic [31:0]   t1, t2, s0, s1, x15, x2;
        w = '0;
        for (int i = 0; i < 16; i++)
            w[i*32 +: 32] = blk[(15-i)*32 +: 32];
        for (int i = 16; i < 64; i++) begin
            x15 = w[(i-15)*32 +: 32];
            x2  = w[(i-2)*32 +: 32];
            s0  = rotr(x15, 7) ^ rotr(x15, 18) ^ (x15 >> 3);
            s1  = rotr(x2, 17) ^ rotr(x2, 19) ^ (x2 >> 10);
            w[i*32 +: 32] = w[(i-16)*32 +: 32] + s0
                          + w[(i-7)*32 +: 32] + s1;
        end
        {a, b, c, d, e, f, g, h} = SHA256_H0;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g))
               + SHA256_K[(63-i)*32 +: 32] + w[i*32 +: 32];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g;
            g = f;
            f = e;
            e = d + t1;
            d = c;
            c = b;
            b = a;
            a = t1 + t2;
        end
        sha256_block = {
            SHA256_H0[255:224] + a, SHA256_H0[223:192] + b,
            SHA256_H0[191:160] + c, SHA256_H0[159:128] + d,
            SHA256_H0[127:96]  + e, SHA256_H0[95:64]   + f,
            SHA256_H0[63:32]   + g, SHA256_H0[31:0]    + h
        };
    endfunction

    // "projectfpga.com" (15 bytes) padded to one block, length 120 bits.
    localparam logic [511:0] PROJECTFPGA_BLOCK = {
        120'h70726f6a656374667067612e636f6d,
        8'h80, 320'd0, 64'd120
    };

    localparam logic [255:0] PROJECTFPGA_DIGEST =
        sha256_block(PROJECTFPGA_BLOCK);

endpackage

// File: rtl/sha256_digest_collector_if.sv
// Hash word stream in, assembled digest out under valid/ack.
// master drives the stream and ack; slave is the collector.
interface sha256_digest_collector_if #(
    parameter int WORD_W   = sha256_pkg::WORD_W,
    parameter int DIGEST_W = sha256_pkg::DIGEST_W
) ();

    logic                hash_valid;
    logic                hash_last;
    logic [WORD_W-1:0]   hash_word;
    logic                digest_ack;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;

    modport master (
        output hash_valid, hash_last, hash_word, digest_ack,
        input  digest, digest_valid
    );

    modport slave (
        input  hash_valid, hash_last, hash_word, digest_ack,
        output digest, digest_valid
    );

endinterface

// File: rtl/sha256_word_shifter.sv
// Word shift register plus received-word counter.
// o_next is the value the register takes on the next load.
module sha256_word_shifter #(
    parameter int WORD_W   = 16,
    parameter int DIGEST_W = 256,
    parameter int CNT_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic [WORD_W-1:0]   i_word,
    output logic [DIGEST_W-1:0] o_next,
    output logic [CNT_W-1:0]    o_count
);

    import sha256_pkg::*;

    logic [DIGEST_W-1:0] r_shift;
    logic [CNT_W-1:0]    r_count;
    logic [WORD_W-1:0]   w_unused_top;

    // Oldest word falls off the top as each new word enters the bottom.
    assign {w_unused_top, o_next} = {r_shift, i_word};
    assign o_count = r_count;

    // Shift on load; clear wins over increment so a closing word resets.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else begin
            if (i_load)
                r_shift <= o_next;
            if (i_clear)
                r_count <= '0;
            else if (i_load)
                r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_digest_collector.sv
// Reassembles the 16-bit SHA256 output stream into a 256-bit digest.
// Optional comparator: define SHA256_DIGEST_COMPARE_EN.
module sha256_digest_collector #(
    parameter int  WORD_W   = sha256_pkg::WORD_W,
    parameter int  DIGEST_W = sha256_pkg::DIGEST_W,
    localparam int CNT_W    = $clog2(DIGEST_W / WORD_W + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    sha256_digest_collector_if.slave  bus,
    output logic [CNT_W-1:0]          word_count,
    output logic                      length_error,
`ifdef SHA256_DIGEST_COMPARE_EN
    output logic                      overrun_error,
    input  logic [DIGEST_W-1:0]       expected_digest,
    output logic                      digest_match
`else
    output logic                      overrun_error
`endif
);

    import sha256_pkg::*;

    localparam int N_WORDS = DIGEST_W / WORD_W;
    localparam logic [CNT_W:0] L_FULL = (CNT_W+1)'(N_WORDS);
    localparam logic [CNT_W:0] L_OVER = (CNT_W+1)'(N_WORDS + 1);

    collect_state_t      r_state;
    collect_state_t      w_next_state;
    logic                w_accept;
    logic                w_load;
    logic                w_clear;
    logic                w_complete;
    logic                w_len_err;
    logic                w_overrun;
    logic                w_release;
    logic [CNT_W:0]      w_new_count;
    logic [DIGEST_W-1:0] w_assembled;

    sha256_word_shifter #(
        .WORD_W   (WORD_W),
        .DIGEST_W (DIGEST_W),
        .CNT_W    (CNT_W)
    ) u_shifter (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_word  (bus.hash_word),
        .o_next  (w_assembled),
        .o_count (word_count)
    );

    // One extra bit so the overrun count N_WORDS+1 is representable.
    assign w_new_count = {1'b0, word_count} + 1'b1;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= COLLECT_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next state: completion, then length fault, then plain accept.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            COLLECT_IDLE, COLLECT_RUN: begin
                if (w_complete)
                    w_next_state = COLLECT_HOLD;
                else if (w_len_err)
                    w_next_state = COLLECT_IDLE;
                else if (w_accept)
                    w_next_state = COLLECT_RUN;
            end
            COLLECT_HOLD: begin
                if (w_complete)
                    w_next_state = COLLECT_HOLD;
                else if (w_len_err)
                    w_next_state = COLLECT_IDLE;
                else if (w_accept)
                    w_next_state = COLLECT_RUN;
                else if (w_release)
                    w_next_state = COLLECT_IDLE;
            end
            default: w_next_state = COLLECT_IDLE;
        endcase
    end

    // Per-cycle decisions; count is always zero outside COLLECT_RUN.
    always_comb begin
        w_accept   = bus.hash_valid
                   && ((r_state != COLLECT_HOLD) || bus.digest_ack);
        w_complete = w_accept && bus.hash_last
                   && (w_new_count == L_FULL);
        w_len_err  = w_accept
                   && (bus.hash_last ? (w_new_count != L_FULL)
                                     : (w_new_count == L_OVER));
        w_load     = w_accept
                   && (bus.hash_last || (w_new_count != L_OVER));
        w_clear    = w_complete || w_len_err;
        w_overrun  = (r_state == COLLECT_HOLD) && bus.hash_valid
                   && !bus.digest_ack;
        w_release  = (r_state == COLLECT_HOLD) && bus.digest_ack;
    end

    // Registered digest, valid flag and single-cycle error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.digest       <= '0;
            bus.digest_valid <= 1'b0;
            length_error     <= 1'b0;
            overrun_error    <= 1'b0;
        end else begin
            length_error  <= w_len_err;
            overrun_error <= w_overrun;
            if (w_complete) begin
                bus.digest       <= w_assembled;
                bus.digest_valid <= 1'b1;
            end else if (w_release) begin
                bus.digest_valid <= 1'b0;
            end
        end
    end

`ifdef SHA256_DIGEST_COMPARE_EN
    // Match flag follows digest_valid: set on completion, cleared on ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            digest_match <= 1'b0;
        else if (w_complete)
            digest_match <= (w_assembled == expected_digest);
        else if (w_release)
            digest_match <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_sha256_digest_collector.sv
// Directed bench for sha256_digest_collector with a digest scoreboard.
// Define SHA256_DIGEST_COMPARE_EN to also exercise digest_match.
module tb_sha256_digest_collector;

    import sha256_pkg::*;

    localparam int CW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic [CW-1:0] word_count;
    logic          length_error;
    logic          overrun_error;
`ifdef SHA256_DIGEST_COMPARE_EN
    logic [255:0]  expected_digest;
    logic          digest_match;
`endif

    int            checks   = 0;
    int            failures = 0;
    logic [255:0]  sb [$];
    logic          dv_prev  = 1'b0;
    logic [255:0]  d1, d2, d3, d4;

    sha256_digest_collector_if #(.WORD_W(16), .DIGEST_W(256)) bus ();

    sha256_digest_collector #(.WORD_W(16), .DIGEST_W(256)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .word_count      (word_count),
        .length_error    (length_error),
`ifdef SHA256_DIGEST_COMPARE_EN
        .overrun_error   (overrun_error),
        .expected_digest (expected_digest),
        .digest_match    (digest_match)
`else
        .overrun_error   (overrun_error)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic last,
                        input logic ack);
        bus.hash_valid = 1'b1;
        bus.hash_word  = w;
        bus.hash_last  = last;
        bus.digest_ack = ack;
        tick();
        bus.hash_valid = 1'b0;
        bus.hash_last  = 1'b0;
        bus.digest_ack = 1'b0;
    endtask

    task automatic send_digest(input logic [255:0] d);
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                sb.push_back(d);
            send(d[255-16*i -: 16], i == 15, 1'b0);
        end
    endtask

    task automatic do_ack();
        bus.digest_ack = 1'b1;
        tick();
        bus.digest_ack = 1'b0;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    // Scoreboard: every new digest_valid must match the oldest pending digest.
    always @(posedge clock) begin
        #1;
        if (bus.digest_valid === 1'b1 && dv_prev !== 1'b1) begin
            chk("sb_pending", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0)
                chk("sb_digest", bus.digest, sb.pop_front());
        end
        dv_prev = bus.digest_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        bus.hash_valid = 1'b0;
        bus.hash_last  = 1'b0;
        bus.hash_word  = '0;
        bus.digest_ack = 1'b0;
`ifdef SHA256_DIGEST_COMPARE_EN
        expected_digest = PROJECTFPGA_DIGEST;
`endif
        repeat (2) tick();
        chk("rst_digest", bus.digest, 256'(0));
        chk("rst_valid", 256'(bus.digest_valid), 256'(0));
        chk("rst_count", 256'(word_count), 256'(0));
        chk("rst_len", 256'(length_error), 256'(0));
        chk("rst_ovr", 256'(overrun_error), 256'(0));
        reset = 1'b1;
        tick();

        // hash_last alone is ignored
        bus.hash_last = 1'b1;
        tick();
        bus.hash_last = 1'b0;
        chk("last_only_len", 256'(length_error), 256'(0));
        chk("last_only_cnt", 256'(word_count), 256'(0));

        // words 0x0001..0x0010
        d1 = '0;
        for (int i = 0; i < 16; i++) begin
            d1 = {d1[239:0], 16'(i + 1)};
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                sb.push_back(d1);
            send(16'(i + 1), i == 15, 1'b0);
            if (i == 7)
                chk("seq_count_mid", 256'(word_count), 256'(8));
        end
        chk("seq_valid", 256'(bus.digest_valid), 256'(1));
        chk("seq_digest", bus.digest,
            256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010);
        chk("seq_count_end", 256'(word_count), 256'(0));
        do_ack();
        chk("seq_ack_valid", 256'(bus.digest_valid), 256'(0));
        chk("seq_ack_state", 256'(dut.r_state), 256'(COLLECT_IDLE));

        // reference digest, match then mismatch
        send_digest(PROJECTFPGA_DIGEST);
        chk("pf_digest", bus.digest, PROJECTFPGA_DIGEST);
`ifdef SHA256_DIGEST_COMPARE_EN
        chk("pf_match", 256'(digest_match), 256'(1));
`endif
        do_ack();
`ifdef SHA256_DIGEST_COMPARE_EN
        chk("pf_match_clr", 256'(digest_match), 256'(0));
        expected_digest = PROJECTFPGA_DIGEST ^ 256'd1;
`endif
        send_digest(PROJECTFPGA_DIGEST);
        chk("pf2_valid", 256'(bus.digest_valid), 256'(1));
`ifdef SHA256_DIGEST_COMPARE_EN
        chk("pf_nomatch", 256'(digest_match), 256'(0));
`endif
        do_ack();

        // short stream: last on word 10
        for (int i = 0; i < 10; i++)
            send(16'(16'h1000 + i), i == 9, 1'b0);
        chk("short_len", 256'(length_error), 256'(1));
        chk("short_valid", 256'(bus.digest_valid), 256'(0));
        chk("short_count", 256'(word_count), 256'(0));
        tick();
        chk("short_len_once", 256'(length_error), 256'(0));

        // long stream: 17 words, no last
        for (int i = 0; i < 17; i++) begin
            send(16'(16'h2000 + i), 1'b0, 1'b0);
            if (i == 15) begin
                chk("long_count16", 256'(word_count), 256'(16));
                chk("long_no_err", 256'(length_error), 256'(0));
            end
        end
        chk("long_len", 256'(length_error), 256'(1));
        chk("long_count", 256'(word_count), 256'(0));
        chk("long_valid", 256'(bus.digest_valid), 256'(0));
        tick();
        chk("long_len_once", 256'(length_error), 256'(0));

        // overrun while pending
        d2 = rnd256();
        send_digest(d2);
        send(16'hdead, 1'b0, 1'b0);
        chk("ovr_pulse", 256'(overrun_error), 256'(1));
        chk("ovr_digest", bus.digest, d2);
        chk("ovr_valid", 256'(bus.digest_valid), 256'(1));
        chk("ovr_count", 256'(word_count), 256'(0));
        tick();
        chk("ovr_once", 256'(overrun_error), 256'(0));

        // ack together with first word of next stream
        d3 = rnd256();
        send(d3[255 -: 16], 1'b0, 1'b1);
        chk("ackw_valid", 256'(bus.digest_valid), 256'(0));
        chk("ackw_count", 256'(word_count), 256'(1));
        for (int i = 1; i < 16; i++) begin
            if (i == 15)
                sb.push_back(d3);
            send(d3[255-16*i -: 16], i == 15, 1'b0);
        end
        chk("d3_valid", 256'(bus.digest_valid), 256'(1));
        do_ack();

        // asynchronous reset mid-stream
        d4 = rnd256();
        for (int i = 0; i < 8; i++)
            send(d4[255-16*i -: 16], 1'b0, 1'b0);
        chk("pre_rst_count", 256'(word_count), 256'(8));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_digest", bus.digest, 256'(0));
        chk("arst_count", 256'(word_count), 256'(0));
        chk("arst_valid", 256'(bus.digest_valid), 256'(0));
        chk("arst_state", 256'(dut.r_state), 256'(COLLECT_IDLE));
        #2;
        reset = 1'b1;
        tick();
        send_digest(d4);
        chk("d4_valid", 256'(bus.digest_valid), 256'(1));
        do_ack();
        tick();
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
